// File: rtl/mtp_pkg.sv
// Shared types for the multi-threaded pipeline: thread states, context layout
// and the fetch stride.
package mtp_pkg;

  localparam int CTX_PC_W     = 32;
  localparam int CTX_CNT_W    = 4;
  localparam int FETCH_STRIDE = 4;

  typedef enum logic [1:0] {
    IDLE,
    READY,
    STALL,
    BLOCKED
  } thread_state_e;

  typedef struct packed {
    thread_state_e          state;
    logic [CTX_PC_W-1:0]    pc;
    logic [CTX_CNT_W-1:0]   cnt;
  } thread_ctx_t;

endpackage

// File: rtl/mtp_rr_arb.sv
// Combinational rotate-priority arbiter: grants the first requester at or
// after ptr, searching upward and wrapping.
module mtp_rr_arb #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          grant_valid,
  output logic [IW-1:0] grant
);

  logic [IW-1:0] idx;

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  // Walk offsets from farthest to nearest so the nearest requester wins last.
  always_comb begin
    grant_valid = |req;
    grant       = '0;
    idx         = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = wrap_add(ptr, k);
      if (req[idx]) grant = idx;
    end
  end

endmodule

// File: rtl/mtp_thread_sched.sv
// Thread scheduler: per-thread context FSMs plus a round-robin fetch offer
// to the instruction fetch unit.
module mtp_thread_sched
  import mtp_pkg::*;
#(
  parameter int NUM_THREADS = 4,
  parameter int PC_WIDTH    = CTX_PC_W,
  parameter int STALL_W     = CTX_CNT_W,
  parameter int TID_W       = $clog2(NUM_THREADS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_valid,
  input  logic [TID_W-1:0]       start_tid,
  input  logic [PC_WIDTH-1:0]    start_pc,
  output logic                   fetch_valid,
  output logic [TID_W-1:0]       fetch_tid,
  output logic [PC_WIDTH-1:0]    fetch_pc,
  input  logic                   fetch_ready,
  input  logic                   redirect_valid,
  input  logic [TID_W-1:0]       redirect_tid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  input  logic                   stall_valid,
  input  logic [TID_W-1:0]       stall_tid,
  input  logic [STALL_W-1:0]     stall_cycles,
  input  logic                   block_valid,
  input  logic [TID_W-1:0]       block_tid,
  input  logic                   wake_valid,
  input  logic [TID_W-1:0]       wake_tid,
  input  logic                   halt_valid,
  input  logic [TID_W-1:0]       halt_tid,
  output logic [NUM_THREADS-1:0] thread_active,
  output logic                   all_idle
);

  if (PC_WIDTH != CTX_PC_W || STALL_W != CTX_CNT_W) begin : g_width_check
    $error("mtp_thread_sched: PC_WIDTH/STALL_W must match mtp_pkg context widths");
  end

  logic [PC_WIDTH-1:0]    pc_q [NUM_THREADS];
  logic [NUM_THREADS-1:0] ready_vec;
  logic [TID_W-1:0]       rr_ptr;
  logic [TID_W-1:0]       grant_tid;
  logic                   grant_valid;
  logic                   accept;

  mtp_rr_arb #(
    .N  (NUM_THREADS),
    .IW (TID_W)
  ) u_arb (
    .req         (ready_vec),
    .ptr         (rr_ptr),
    .grant_valid (grant_valid),
    .grant       (grant_tid)
  );

  // Fetch handshake: the offer (fetch_valid/tid/pc) is combinational from
  // registered state and may change or drop while unaccepted; a transfer
  // happens only on a clock edge where fetch_valid && fetch_ready.
  assign fetch_valid = grant_valid;
  assign fetch_tid   = grant_valid ? grant_tid : '0;
  assign fetch_pc    = grant_valid ? pc_q[grant_tid] : '0;
  assign accept      = grant_valid & fetch_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (grant_tid == TID_W'(NUM_THREADS - 1)) ? '0 : grant_tid + TID_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_THREADS; i++) begin : g_thr
    localparam logic [TID_W-1:0] TID = TID_W'(i);

    thread_ctx_t cur_q;
    thread_ctx_t nxt;
    logic        hit_start, hit_redirect, hit_stall, hit_block;
    logic        hit_wake, hit_halt, hit_fetch, stall_go;

    assign hit_start    = start_valid    && (start_tid    == TID);
    assign hit_redirect = redirect_valid && (redirect_tid == TID);
    assign hit_stall    = stall_valid    && (stall_tid    == TID);
    assign hit_block    = block_valid    && (block_tid    == TID);
    assign hit_wake     = wake_valid     && (wake_tid     == TID);
    assign hit_halt     = halt_valid     && (halt_tid     == TID);
    assign hit_fetch    = accept         && (grant_tid    == TID);
    assign stall_go     = hit_stall && (stall_cycles != '0);

    // State follows halt > block > stall; pc follows redirect > fetch advance.
    always_comb begin
      nxt = cur_q;
      if (hit_halt) begin
        nxt.state = IDLE;
        nxt.cnt   = '0;
      end else begin
        case (cur_q.state)
          IDLE: begin
            if (hit_start) begin
              nxt.state = READY;
              nxt.pc    = start_pc;
            end
          end
          READY: begin
            if (hit_block) begin
              nxt.state = BLOCKED;
            end else if (stall_go) begin
              nxt.state = STALL;
              nxt.cnt   = stall_cycles;
            end
          end
          STALL: begin
            if (hit_block) begin
              nxt.state = BLOCKED;
              nxt.cnt   = '0;
            end else if (stall_go) begin
              nxt.cnt = stall_cycles;
            end else if (cur_q.cnt == STALL_W'(1)) begin
              nxt.state = READY;
              nxt.cnt   = '0;
            end else begin
              nxt.cnt = cur_q.cnt - STALL_W'(1);
            end
          end
          BLOCKED: begin
            if (hit_wake) nxt.state = READY;
          end
          default: nxt = cur_q;
        endcase
        if (cur_q.state != IDLE) begin
          if (hit_redirect)   nxt.pc = redirect_pc;
          else if (hit_fetch) nxt.pc = cur_q.pc + PC_WIDTH'(FETCH_STRIDE);
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cur_q <= '{state: IDLE, pc: '0, cnt: '0};
      end else begin
        cur_q <= nxt;
      end
    end

    assign pc_q[i]          = cur_q.pc;
    assign ready_vec[i]     = (cur_q.state == READY);
    assign thread_active[i] = (cur_q.state != IDLE);
  end

  assign all_idle = ~|thread_active;

endmodule

// File: tb/tb_mtp_thread_sched.sv
// Directed bench for mtp_thread_sched: expected fetch transfers are queued by
// the stimulus and consumed by an independent monitor.
module tb_mtp_thread_sched;

  localparam int NT  = 4;
  localparam int PCW = 32;
  localparam int SW  = 4;
  localparam int TW  = 2;
  localparam int W   = TW + PCW;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start_valid, fetch_ready, redirect_valid, stall_valid;
  logic           block_valid, wake_valid, halt_valid;
  logic [TW-1:0]  start_tid, redirect_tid, stall_tid, block_tid, wake_tid, halt_tid;
  logic [PCW-1:0] start_pc, redirect_pc;
  logic [SW-1:0]  stall_cycles;
  logic           fetch_valid, all_idle;
  logic [TW-1:0]  fetch_tid;
  logic [PCW-1:0] fetch_pc;
  logic [NT-1:0]  thread_active;

  int             checks = 0;
  int             errors = 0;
  logic [W-1:0]   exp_q[$];
  logic [W-1:0]   want;

  always #5 clk = ~clk;

  mtp_thread_sched #(
    .NUM_THREADS (NT),
    .PC_WIDTH    (PCW),
    .STALL_W     (SW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start_valid    (start_valid),
    .start_tid      (start_tid),
    .start_pc       (start_pc),
    .fetch_valid    (fetch_valid),
    .fetch_tid      (fetch_tid),
    .fetch_pc       (fetch_pc),
    .fetch_ready    (fetch_ready),
    .redirect_valid (redirect_valid),
    .redirect_tid   (redirect_tid),
    .redirect_pc    (redirect_pc),
    .stall_valid    (stall_valid),
    .stall_tid      (stall_tid),
    .stall_cycles   (stall_cycles),
    .block_valid    (block_valid),
    .block_tid      (block_tid),
    .wake_valid     (wake_valid),
    .wake_tid       (wake_tid),
    .halt_valid     (halt_valid),
    .halt_tid       (halt_tid),
    .thread_active  (thread_active),
    .all_idle       (all_idle)
  );

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic exp_offer(input logic [TW-1:0] tid, input logic [PCW-1:0] pc);
    exp_q.push_back({tid, pc});
  endtask

  // Monitor: every accepted offer must match the head of the expected queue.
  always @(negedge clk) begin
    if (!reset && fetch_valid && fetch_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL fetch_unexpected: got tid=%0d pc=%h, want no transfer", fetch_tid, fetch_pc);
      end else begin
        want = exp_q.pop_front();
        if ({fetch_tid, fetch_pc} !== want) begin
          errors++;
          $display("FAIL fetch_offer: got tid=%0d pc=%h, want tid=%0d pc=%h",
                   fetch_tid, fetch_pc, want[W-1:PCW], want[PCW-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
    start_valid    = 1'b0;
    redirect_valid = 1'b0;
    stall_valid    = 1'b0;
    block_valid    = 1'b0;
    wake_valid     = 1'b0;
    halt_valid     = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic drv_start(input logic [TW-1:0] tid, input logic [PCW-1:0] pc);
    start_valid = 1'b1; start_tid = tid; start_pc = pc;
  endtask

  task automatic drv_redirect(input logic [TW-1:0] tid, input logic [PCW-1:0] pc);
    redirect_valid = 1'b1; redirect_tid = tid; redirect_pc = pc;
  endtask

  task automatic drv_stall(input logic [TW-1:0] tid, input logic [SW-1:0] n);
    stall_valid = 1'b1; stall_tid = tid; stall_cycles = n;
  endtask

  task automatic drv_block(input logic [TW-1:0] tid);
    block_valid = 1'b1; block_tid = tid;
  endtask

  task automatic drv_wake(input logic [TW-1:0] tid);
    wake_valid = 1'b1; wake_tid = tid;
  endtask

  task automatic drv_halt(input logic [TW-1:0] tid);
    halt_valid = 1'b1; halt_tid = tid;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fetch_valid"},   fetch_valid,   0);
    check({tag, "_fetch_tid"},     fetch_tid,     0);
    check({tag, "_fetch_pc"},      fetch_pc,      0);
    check({tag, "_thread_active"}, thread_active, 0);
    check({tag, "_all_idle"},      all_idle,      1);
  endtask

  task automatic do_reset(input string tag);
    fetch_ready = 1'b0;
    reset = 1'b1;
    #1;
    check_reset_outputs(tag);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, want normal finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    start_valid = 0; redirect_valid = 0; stall_valid = 0; block_valid = 0;
    wake_valid = 0; halt_valid = 0; fetch_ready = 0;
    start_tid = 0; redirect_tid = 0; stall_tid = 0; block_tid = 0;
    wake_tid = 0; halt_tid = 0; start_pc = 0; redirect_pc = 0; stall_cycles = 0;
    #1;
    do_reset("por");

    // Single thread: consecutive offers advance by 4.
    drv_start(0, 32'h100);
    cycle();
    check("t1_active", thread_active, 4'b0001);
    check("t1_all_idle", all_idle, 0);
    check("t1_valid", fetch_valid, 1);
    fetch_ready = 1'b1;
    exp_offer(0, 32'h100); exp_offer(0, 32'h104); exp_offer(0, 32'h108);
    run(3);
    fetch_ready = 1'b0;
    drv_halt(0);
    cycle();
    check("t1_halt_idle", all_idle, 1);
    check("t1_halt_valid", fetch_valid, 0);

    // Four threads in full rotation.
    do_reset("rst2");
    for (int t = 0; t < NT; t++) begin
      drv_start(TW'(t), PCW'(t * 32'h1000));
      cycle();
    end
    check("t2_active", thread_active, 4'b1111);
    fetch_ready = 1'b1;
    exp_offer(0, 32'h0); exp_offer(1, 32'h1000); exp_offer(2, 32'h2000);
    exp_offer(3, 32'h3000); exp_offer(0, 32'h4);
    run(5);
    fetch_ready = 1'b0;

    // tid1 stalled 3 cycles: rr_ptr=1 at this point.
    drv_stall(1, 4'd3);
    cycle();
    check("t3_active", thread_active, 4'b1111);
    fetch_ready = 1'b1;
    exp_offer(2, 32'h2004); exp_offer(3, 32'h3004); exp_offer(0, 32'h8);
    exp_offer(1, 32'h1004); exp_offer(2, 32'h2008); exp_offer(3, 32'h3008);
    exp_offer(0, 32'hC);    exp_offer(1, 32'h1008);
    run(8);
    fetch_ready = 1'b0;

    // tid2 blocked, woken 10 cycles later; rr_ptr=2 here.
    drv_block(2);
    cycle();
    check("t4_active", thread_active, 4'b1111);
    fetch_ready = 1'b1;
    exp_offer(3, 32'h300C); exp_offer(0, 32'h10);   exp_offer(1, 32'h100C);
    exp_offer(3, 32'h3010); exp_offer(0, 32'h14);   exp_offer(1, 32'h1010);
    exp_offer(3, 32'h3014); exp_offer(0, 32'h18);   exp_offer(1, 32'h1014);
    exp_offer(3, 32'h3018); exp_offer(0, 32'h1C);   exp_offer(1, 32'h1018);
    exp_offer(2, 32'h200C);
    run(9);
    drv_wake(2);
    run(4);
    fetch_ready = 1'b0;
    drv_wake(2);
    cycle();
    fetch_ready = 1'b1;
    exp_offer(3, 32'h301C);
    cycle();
    fetch_ready = 1'b0;

    // Redirect wins over fetch advance; start on a live thread is ignored.
    do_reset("rst5");
    drv_start(0, 32'h200);
    cycle();
    fetch_ready = 1'b1;
    drv_redirect(0, 32'h800);
    exp_offer(0, 32'h200); exp_offer(0, 32'h800);
    run(2);
    fetch_ready = 1'b0;
    drv_start(0, 32'h300);
    cycle();
    fetch_ready = 1'b1;
    exp_offer(0, 32'h804);
    cycle();
    fetch_ready = 1'b0;
    drv_halt(0);
    drv_redirect(0, 32'h900);
    cycle();
    check("t5_halt_idle", all_idle, 1);
    check("t5_halt_active", thread_active, 0);
    check("t5_halt_valid", fetch_valid, 0);

    // PC wrap, zero-length stall, short stall, then reset mid-stall.
    do_reset("rst6");
    drv_start(0, 32'hFFFF_FFFC);
    cycle();
    fetch_ready = 1'b1;
    exp_offer(0, 32'hFFFF_FFFC); exp_offer(0, 32'h0);
    run(2);
    drv_stall(0, 4'd0);
    exp_offer(0, 32'h4);
    cycle();
    fetch_ready = 1'b0;
    drv_stall(0, 4'd2);
    cycle();
    fetch_ready = 1'b1;
    exp_offer(0, 32'h8);
    run(3);
    fetch_ready = 1'b0;
    drv_stall(0, 4'd5);
    cycle();
    check("t6_stall_active", thread_active, 4'b0001);
    check("t6_stall_valid", fetch_valid, 0);
    do_reset("mid_stall");
    fetch_ready = 1'b1;
    run(6);
    fetch_ready = 1'b0;
    check("t6_post_reset_idle", all_idle, 1);
    check("t6_post_reset_valid", fetch_valid, 0);

    check("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mtp_thread_sched.md
# mtp_thread_sched

Thread scheduler for the multi-threaded pipeline, the parametrised successor of the single-threaded pipeline top. It holds NUM_THREADS hardware thread contexts, each with a PC and a state machine, and picks one READY thread per cycle to offer to the instruction fetch unit. Thread choice uses round-robin arbitration. Execution, lane and memory events drive the per-thread state transitions.

## Interface
- NUM_THREADS, 4: thread contexts, ≥2.
- PC_WIDTH, 32: PC width.
- STALL_W, 4: stall-count width.
- TID_W, $clog2(NUM_THREADS): thread-id width (derived).
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- start_valid / start_tid / start_pc  in  1 / TID_W / PC_WIDTH  launch thread at PC.
- fetch_valid  out  1  fetch offer present.
- fetch_tid  out  TID_W  offered thread.
- fetch_pc  out  PC_WIDTH  offered PC.
- fetch_ready  in  1  fetch unit accepts offer.
- redirect_valid / redirect_tid / redirect_pc  in  1 / TID_W / PC_WIDTH  branch redirect from execution.
- stall_valid / stall_tid / stall_cycles  in  1 / TID_W / STALL_W  timed stall (lane busy).
- block_valid / block_tid  in  1 / TID_W  thread waits on memory.
- wake_valid / wake_tid  in  1 / TID_W  memory return for blocked thread.
- halt_valid / halt_tid  in  1 / TID_W  thread finished.
- thread_active  out  NUM_THREADS  bit i = thread i not IDLE.
- all_idle  out  1  every thread IDLE.

## Operation
- Per-thread states:
  - IDLE: start → READY, pc ← start_pc.
  - READY: eligible for fetch.
  - STALL: counter running.
  - BLOCKED: wake → READY.
- Event priority when several hit the same thread in one cycle: halt > block > stall > redirect > fetch acceptance.
- halt: any state → IDLE. block: READY/STALL → BLOCKED.
- stall with stall_cycles=0: ignored. Non-zero, from READY: → STALL, cnt ← stall_cycles.
- Stall on a STALL thread reloads cnt. Stall on an IDLE or BLOCKED thread: ignored.
- STALL: cnt decrements each cycle. At cnt==1 the thread moves → READY. The thread is therefore non-eligible for exactly stall_cycles cycles.
- redirect: pc ← redirect_pc in any non-IDLE state; state unchanged. Redirect to an IDLE thread is ignored.
- Redirect in the same cycle as fetch acceptance for the same thread: pc ← redirect_pc (no +4). Squash of the accepted wrong-path fetch belongs to the execution unit.
- start on a non-IDLE thread: ignored. wake on a non-BLOCKED thread: ignored.
- Fetch offer: combinational from registered state. fetch_valid = any READY thread.
- fetch_tid = first READY thread at or after rr_ptr, searching upward and wrapping.
- fetch_pc = pc of the offered thread. fetch_tid/fetch_pc drive 0 when fetch_valid=0.
- Acceptance when fetch_valid && fetch_ready at the edge:
  - pc[tid] ← pc[tid]+4, modulo 2^PC_WIDTH.
  - rr_ptr ← (tid+1) mod NUM_THREADS.
- The offer may change or drop without acceptance when events remove the thread from READY. The fetch unit samples only on acceptance.
- thread_active and all_idle derive from registered state.

## Timing
- Reset (async assert, sync-safe deassert):
  - all threads IDLE, all pc=0, cnt=0, rr_ptr=0.
  - fetch_valid=0, fetch_tid=0, fetch_pc=0.
  - thread_active=0, all_idle=1.
- start at edge N: thread READY and offerable in cycle N+1 (same cycle as the state change, zero added latency).
- Acceptance at edge N: the next offer in cycle N+1 reflects the advanced rr_ptr and pc.
- Fully loaded (all threads READY, fetch_ready=1): each thread is offered once every NUM_THREADS cycles.
- Reset mid-operation: everything returns to reset values immediately. Pending stall counts and blocks are discarded.

## Structure
- Package mtp_pkg holds:
  - thread_state_e {IDLE, READY, STALL, BLOCKED}
  - FETCH_STRIDE=4
  - thread context struct {state, pc, cnt}
- Sub-module mtp_rr_arb, parametrised N: inputs req vector and ptr; outputs grant_valid and grant index; combinational rotate-priority.
- Per-thread context update in a generate loop.

## Test plan
- Reset, then start tid0 pc=0x100 with fetch_ready=1 → offers 0x100, 0x104, 0x108 on consecutive cycles; thread_active=0001, all_idle=0.
- Start all 4 threads, pc = 0x0, 0x1000, 0x2000, 0x3000, fetch_ready=1 → fetch_tid sequence 0,1,2,3,0; each pc +4 per visit.
- tid1 stall_cycles=3 while 4 threads READY → tid1 absent from offers for exactly 3 cycles, then rejoins rotation at pc unchanged.
- tid2 block, then wake 10 cycles later → tid2 not offered in between. A wake sent while tid2 is READY is ignored.
- Same-cycle acceptance of tid0 at 0x200 and redirect tid0→0x800 → next tid0 offer pc=0x800. Same-cycle halt+redirect → tid0 IDLE.
- pc=0xFFFF_FFFC accepted → pc wraps to 0x0. Assert reset mid-stall → all outputs at reset values, all_idle=1.
